// File: rtl/sleep_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sleep_clock_ctrl
// Purpose  : CPU sleep / clock-enable controller with a prescaled sleep timer
//            and masked early-wake sources. Produces a registered clock enable.
// Revision : 1.0 - initial release
// ============================================================================
module sleep_clock_ctrl #(
    parameter int COUNT_W  = 16,
    parameter int DIV_W    = 5,
    parameter int NUM_WAKE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run_en,
    input  logic                sleep_req,
    input  logic [COUNT_W-1:0]  sleep_value,
    input  logic [DIV_W-1:0]    sleep_div,
    input  logic [NUM_WAKE-1:0] wake_mask,
    input  logic [NUM_WAKE-1:0] wake_src,
    output logic                cpu_clk_en,
    output logic                asleep,
    output logic [COUNT_W-1:0]  remaining,
    output logic                done,
    output logic                woke,
    output logic [NUM_WAKE-1:0] wake_cause
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_SLEEP = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [COUNT_W-1:0]    remaining_q, remaining_d;
    logic [DIV_W-1:0]      presc_q, presc_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  clk_en_q, clk_en_d;
    logic                  asleep_q, asleep_d;
    logic                  done_q, done_d;
    logic                  woke_q, woke_d;
    logic [NUM_WAKE-1:0]   cause_q, cause_d;
    logic [NUM_WAKE-1:0]   wake_hit;

    assign wake_hit = wake_src & wake_mask;

    // Two nested counters (prescaler inside tick count) avoid forming V*(D+1).
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        presc_d     = presc_q;
        div_d       = div_q;
        clk_en_d    = clk_en_q;
        asleep_d    = asleep_q;
        done_d      = 1'b0;
        woke_d      = 1'b0;
        cause_d     = cause_q;

        case (state_q)
            ST_RUN: begin
                clk_en_d = run_en;
                if (sleep_req && run_en) begin
                    if (sleep_value != '0) begin
                        state_d     = ST_SLEEP;
                        remaining_d = sleep_value;
                        presc_d     = sleep_div;
                        div_d       = sleep_div;
                        cause_d     = '0;
                        clk_en_d    = 1'b0;
                        asleep_d    = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_SLEEP: begin
                if (!run_en) begin
                    clk_en_d = 1'b0;
                end else if (|wake_hit) begin
                    // Wake takes priority over a timeout in the same cycle.
                    state_d     = ST_RUN;
                    remaining_d = '0;
                    presc_d     = '0;
                    clk_en_d    = 1'b1;
                    asleep_d    = 1'b0;
                    woke_d      = 1'b1;
                    cause_d     = wake_hit;
                end else if (presc_q != '0) begin
                    presc_d = presc_q - DIV_W'(1);
                end else if (remaining_q == COUNT_W'(1)) begin
                    state_d     = ST_RUN;
                    remaining_d = '0;
                    clk_en_d    = 1'b1;
                    asleep_d    = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    remaining_d = remaining_q - COUNT_W'(1);
                    presc_d     = div_q;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            remaining_q <= '0;
            presc_q     <= '0;
            div_q       <= '0;
            clk_en_q    <= 1'b0;
            asleep_q    <= 1'b0;
            done_q      <= 1'b0;
            woke_q      <= 1'b0;
            cause_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            presc_q     <= presc_d;
            div_q       <= div_d;
            clk_en_q    <= clk_en_d;
            asleep_q    <= asleep_d;
            done_q      <= done_d;
            woke_q      <= woke_d;
            cause_q     <= cause_d;
        end
    end

    assign cpu_clk_en = clk_en_q;
    assign asleep     = asleep_q;
    assign remaining  = remaining_q;
    assign done       = done_q;
    assign woke       = woke_q;
    assign wake_cause = cause_q;

endmodule
`default_nettype wire
